// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// ps2_key_decoder : PS/2 scan-code-set-2 receiver with Space/Left/Right
//                   level-held key decoding for the game controller.
// Revision        : 1.0
// ============================================================================
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_space,
  output logic       key_left,
  output logic       key_right,
  output logic [7:0] scancode,
  output logic       scancode_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] c_filt_last = FW'(FILTER_LEN - 1);
  localparam logic [WW-1:0] c_wd_last   = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fclk_q, fclk_d, fclk_prev_q;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [7:0]    scancode_q, scancode_d;
  logic          valid_q, valid_d, err_q, err_d;
  state_t        state_q, state_d;
  logic          space_q, space_d, left_q, left_d, right_q, right_d;
  logic          fall, frame_ok;

  // Idle-high line: synchronizers and filter come out of reset at 1 so no
  // spurious falling edge is seen after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_cnt_q  <= '0;
      fclk_q      <= 1'b1;
      fclk_prev_q <= 1'b1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      wd_q        <= '0;
      scancode_q  <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      state_q     <= ST_IDLE;
      space_q     <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= ps2_data;
      dat_s2_q    <= dat_s1_q;
      filt_cnt_q  <= filt_cnt_d;
      fclk_q      <= fclk_d;
      fclk_prev_q <= fclk_q;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      wd_q        <= wd_d;
      scancode_q  <= scancode_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      state_q     <= state_d;
      space_q     <= space_d;
      left_q      <= left_d;
      right_q     <= right_d;
    end
  end

  always_comb begin
    filt_cnt_d = '0;
    fclk_d     = fclk_q;
    if (clk_s2_q != fclk_q) begin
      if (filt_cnt_q == c_filt_last) begin
        fclk_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end
  end

  assign fall = fclk_prev_q & ~fclk_q;

  // shift_q after ten bits: [0]=start, [8:1]=D0..D7, [9]=parity; the stop
  // bit is still on the synchronized data line when the eleventh edge hits.
  assign frame_ok = ~shift_q[0] & (^shift_q[9:1]) & dat_s2_q;

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    wd_d       = wd_q;
    scancode_d = scancode_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    if (fall) begin
      wd_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = '0;
        if (frame_ok) begin
          valid_d    = 1'b1;
          scancode_d = shift_q[8:1];
        end else begin
          err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {dat_s2_q, shift_q[9:1]};
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (wd_q == c_wd_last) begin
        wd_d      = '0;
        bit_cnt_d = '0;
        err_d     = 1'b1;
      end else begin
        wd_d = wd_q + WW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    space_d = space_q;
    left_d  = left_q;
    right_d = right_q;
    if (valid_q) begin
      case (state_q)
        ST_IDLE: begin
          if (scancode_q == 8'hE0) begin
            state_d = ST_EXT;
          end else if (scancode_q == 8'hF0) begin
            state_d = ST_BRK;
          end else if (scancode_q == 8'h29) begin
            space_d = 1'b1;
          end
        end
        ST_EXT: begin
          state_d = ST_IDLE;
          if (scancode_q == 8'hF0) begin
            state_d = ST_EXT_BRK;
          end else if (scancode_q == 8'h6B) begin
            left_d = 1'b1;
          end else if (scancode_q == 8'h74) begin
            right_d = 1'b1;
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          if (scancode_q == 8'h29) begin
            space_d = 1'b0;
          end
        end
        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (scancode_q == 8'h6B) begin
            left_d = 1'b0;
          end else if (scancode_q == 8'h74) begin
            right_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign key_space      = space_q;
  assign key_left       = left_q;
  assign key_right      = right_q;
  assign scancode       = scancode_q;
  assign scancode_valid = valid_q;
  assign frame_err      = err_q;

endmodule
`default_nettype wire
